// File: rtl/cordic_pkg.sv
// Shared constants and types for the serial rotation-mode CORDIC.
// Angles are 16-bit binary radians: 32768 == pi.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ITER,
        DONE
    } state_t;

    localparam logic [11:0] INV_CORDIC_GAIN = 12'b010011011011;
    localparam logic signed [15:0] ANGLE_HALF_PI = 16'sd16384;

    // atan(2^-i) * 32768 / pi, rounded
    localparam logic [15:0] ATAN_TAB [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

endpackage

// File: rtl/cordic_serial_rot_if.sv
// Request/result bundle between a client and the rotation CORDIC.
// master drives the request, slave returns busy and the result.
interface cordic_serial_rot_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic [WIDTH-1:0]        data_mag;
    logic [15:0]             data_angle;
    logic                    busy;
    logic                    out_valid;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;

    modport master (
        output start, data_mag, data_angle,
        input  busy, out_valid, x_out, y_out
    );

    modport slave (
        input  start, data_mag, data_angle,
        output busy, out_valid, x_out, y_out
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, one entry per micro-rotation.
// Address is the iteration index; no latency.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]  addr,
    output logic [15:0] atan
);

    always_comb begin
        atan = ATAN_TAB[addr];
    end

endmodule

// File: rtl/cordic_serial_rot.sv
// Serial rotation-mode CORDIC: (mag, angle) -> (mag*cos, mag*sin).
// One micro-rotation per clock; inverse gain applied up front.
module cordic_serial_rot
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = 16
) (
    input logic clk,
    input logic rst_n,
    cordic_serial_rot_if.slave bus
);

    localparam int W2 = WIDTH + 2;
    localparam logic [3:0] LAST = 4'(ITERATIONS - 1);
    localparam logic signed [W2-1:0] SAT_HI = W2'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [W2-1:0] SAT_LO = -SAT_HI;

    state_t                state;
    logic [WIDTH-1:0]      mag;
    logic signed [15:0]    ang;
    logic signed [W2-1:0]  x;
    logic signed [W2-1:0]  y;
    logic signed [15:0]    z;
    logic [3:0]            i;
    logic [15:0]           atan;
    logic signed [W2-1:0]  km;
    logic signed [W2-1:0]  x_sh;
    logic signed [W2-1:0]  y_sh;

    cordic_atan_rom u_rom (
        .addr (i),
        .atan (atan)
    );

    assign km = W2'(((WIDTH+12)'(mag) * (WIDTH+12)'(INV_CORDIC_GAIN)) >> 11);
    assign x_sh = x >>> i;
    assign y_sh = y >>> i;

    function automatic logic signed [WIDTH-1:0] sat(
        input logic signed [W2-1:0] v
    );
        if (v > SAT_HI) return SAT_HI[WIDTH-1:0];
        else if (v < SAT_LO) return SAT_LO[WIDTH-1:0];
        else return v[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mag           <= '0;
            ang           <= '0;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            i             <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mag      <= bus.data_mag;
                        ang      <= bus.data_angle;
                        bus.busy <= 1'b1;
                        state    <= PRE;
                    end
                end
                PRE: begin
                    i     <= '0;
                    state <= ITER;
                    // fold into [-pi/2, pi/2] so the iterations converge
                    unique case (ang[15:14])
                        2'b01: begin
                            x <= '0;
                            y <= km;
                            z <= ang - ANGLE_HALF_PI;
                        end
                        2'b10: begin
                            x <= '0;
                            y <= -km;
                            z <= ang + ANGLE_HALF_PI;
                        end
                        default: begin
                            x <= km;
                            y <= '0;
                            z <= ang;
                        end
                    endcase
                end
                ITER: begin
                    if (z[15]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan;
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan;
                    end
                    i <= i + 4'd1;
                    if (i == LAST) begin
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.out_valid <= 1'b1;
                    bus.x_out     <= sat(x);
                    bus.y_out     <= sat(y);
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_serial_rot.sv
// Directed and random checks of the rotation CORDIC against a
// floating-point polar-to-rectangular model.
module tb_cordic_serial_rot;

    localparam int  TOL = 12;
    localparam real PI  = 3.14159265358979;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    real  kg;

    cordic_serial_rot_if #(.WIDTH(16)) bus ();

    cordic_serial_rot #(
        .WIDTH      (16),
        .ITERATIONS (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ideal rotation of the prescaled magnitude, including the CORDIC gain
    function automatic real ref_x(input int m, input int a);
        real km;
        km = real'((m * 1243) >>> 11);
        return km * kg * $cos(real'(a) * PI / 32768.0);
    endfunction

    function automatic real ref_y(input int m, input int a);
        real km;
        km = real'((m * 1243) >>> 11);
        return km * kg * $sin(real'(a) * PI / 32768.0);
    endfunction

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input real exp);
        int e;
        int d;
        e = int'(exp);
        d = obs - e;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= TOL) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    // entered and left at a falling edge
    task automatic run_op(
        input  int m,
        input  int a,
        output int xo,
        output int yo,
        output int lat,
        output int bc
    );
        bit got;
        bit held;
        int x0;
        int y0;
        bus.start      = 1'b1;
        bus.data_mag   = m[15:0];
        bus.data_angle = a[15:0];
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 0;
        bc   = 0;
        got  = 0;
        held = 1;
        x0   = bus.x_out;
        y0   = bus.y_out;
        for (int c = 0; c < 60; c++) begin
            if (bus.busy) bc++;
            if (bus.out_valid) begin
                got = 1;
                break;
            end
            if (bus.x_out !== x0[15:0] || bus.y_out !== y0[15:0]) held = 0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk_eq("done_seen", int'(got), 1);
        chk_eq("out_held", int'(held), 1);
        xo = bus.x_out;
        yo = bus.y_out;
    endtask

    task automatic op_check(input string tag, input int m, input int a);
        int xo, yo, lat, bc;
        run_op(m, a, xo, yo, lat, bc);
        chk_eq({tag, "_lat"}, lat, 18);
        chk_tol({tag, "_x"}, xo, ref_x(m, a));
        chk_tol({tag, "_y"}, yo, ref_y(m, a));
    endtask

    initial begin
        int xo, yo, lat, bc, nv, vlat, xa, ya, m, a, u;

        kg = 1.0;
        for (int k = 0; k < 16; k++) kg = kg * $sqrt(1.0 + 2.0 ** (-2.0 * k));

        bus.start      = 1'b0;
        bus.data_mag   = '0;
        bus.data_angle = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", int'(bus.busy), 0);
        chk_eq("rst_valid", int'(bus.out_valid), 0);
        chk_eq("rst_x", int'(bus.x_out), 0);
        chk_eq("rst_y", int'(bus.y_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(10000, 0, xo, yo, lat, bc);
        chk_eq("t1_lat", lat, 18);
        chk_eq("t1_busy_cycles", bc, 17);
        chk_tol("t1_x", xo, ref_x(10000, 0));
        chk_tol("t1_y", yo, ref_y(10000, 0));

        op_check("t2_p45", 10000, 8192);
        op_check("t2_m45", 10000, -8192);
        op_check("t3_p90", 10000, 16384);
        op_check("t3_p135", 10000, 24576);
        op_check("t3_m180", 10000, -32768);
        op_check("t3_m90", 10000, -16384);
        op_check("zero_mag", 0, 12345);

        bus.start      = 1'b1;
        bus.data_mag   = 16'd10000;
        bus.data_angle = 16'd8192;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        nv   = 0;
        vlat = 0;
        xa   = 0;
        ya   = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5 || c == 10) begin
                bus.start      = 1'b1;
                bus.data_mag   = 16'd5000;
                bus.data_angle = 16'hE000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                nv++;
                vlat = c;
                xa   = bus.x_out;
                ya   = bus.y_out;
            end
        end
        chk_eq("t4_pulses", nv, 1);
        chk_eq("t4_lat", vlat, 18);
        chk_tol("t4_x", xa, ref_x(10000, 8192));
        chk_tol("t4_y", ya, ref_y(10000, 8192));

        run_op(10000, 0, xo, yo, lat, bc);
        run_op(10000, 16384, xo, yo, lat, bc);
        chk_eq("t4_b2b_lat", lat, 18);
        chk_tol("t4_b2b_x", xo, ref_x(10000, 16384));
        chk_tol("t4_b2b_y", yo, ref_y(10000, 16384));

        op_check("t5_pre", 10000, 4096);
        bus.start      = 1'b1;
        bus.data_mag   = 16'd9000;
        bus.data_angle = 16'd3000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk_eq("t5_busy_before", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t5_busy", int'(bus.busy), 0);
        chk_eq("t5_valid", int'(bus.out_valid), 0);
        chk_eq("t5_x", int'(bus.x_out), 0);
        chk_eq("t5_y", int'(bus.y_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        chk_eq("t5_no_valid", nv, 0);

        for (int k = 0; k < 256; k++) begin
            u = k * 257;
            a = (u >= 32768) ? u - 65536 : u;
            op_check("sweep", 16383, a);
        end

        for (int k = 0; k < 40; k++) begin
            m = int'($urandom_range(0, 16383));
            u = int'($urandom_range(0, 65535));
            a = (u >= 32768) ? u - 65536 : u;
            op_check("rand", m, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
